// File: rtl/cic_acq_ctrl.sv
// Acquisition controller for the 2nd-order CIC decimator.
// Holds the CIC in reset while idle, discards pipeline-fill samples after
// release, captures a programmed number of decimated samples into a
// show-ahead FIFO and streams them out on a valid/ready port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | CIC held in reset, waiting for a start command
// ST_SETTLE | CIC running, decimated samples discarded while the CIC fills
// ST_ACQ    | CIC running, each decimated sample pushed into the FIFO
// ST_DRAIN  | CIC stopped, waiting for downstream to empty the FIFO
module cic_acq_ctrl #(
   parameter int DATA_W         = 20,
   parameter int FIFO_DEPTH     = 8,
   parameter int CNT_W          = 16,
   parameter int SETTLE_SAMPLES = 2
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [CNT_W-1:0]              num_samples_i,
   input  logic [DATA_W-1:0]             cic_data_i,
   input  logic                          cic_clk_i,
   output logic                          cic_rstn_o,
   output logic [DATA_W-1:0]             m_data_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int SET_W = (SETTLE_SAMPLES < 1) ? 1 : $clog2(SETTLE_SAMPLES + 1);
   localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_SAMPLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACQ    = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   sample_cnt_q;
   logic [SET_W-1:0]   settle_cnt_q;
   logic               cic_rstn_q;
   logic               busy_q;
   logic               done_q;
   logic               overflow_q;
   logic               cic_clk_q;

   logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [LVL_W-1:0]   level_q;

   logic               strb;
   logic               pop;
   logic               full;
   logic               push;

   // Rising edge of the decimated clock; same clock domain, so no synchronizer.
   assign strb = cic_clk_i & ~cic_clk_q;
   assign full = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop  = m_valid_o & m_ready_i;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push = (state_q == ST_ACQ) & strb & ~abort_i & (~full | pop);

   assign m_valid_o    = (level_q != '0);
   assign m_data_o     = m_valid_o ? mem_q[rd_ptr_q] : '0;
   assign fifo_level_o = level_q;
   assign cic_rstn_o   = cic_rstn_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign overflow_o   = overflow_q;

   // Delayed copy of the CIC decimated clock for edge detection.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cic_clk_q <= 1'b0;
      else         cic_clk_q <= cic_clk_i;
   end

   // Sequencing FSM with registered CIC reset, busy, done and overflow.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= ST_IDLE;
         sample_cnt_q <= '0;
         settle_cnt_q <= '0;
         cic_rstn_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            // Abort wins over everything; overflow is kept for post-mortem.
            state_q    <= ST_IDLE;
            cic_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i && (num_samples_i != '0)) begin
                     sample_cnt_q <= num_samples_i;
                     settle_cnt_q <= SETTLE_INIT;
                     overflow_q   <= 1'b0;
                     busy_q       <= 1'b1;
                     cic_rstn_q   <= 1'b1;
                     state_q      <= (SETTLE_SAMPLES == 0) ? ST_ACQ : ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (strb) begin
                     if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - SET_W'(1);
                     if (settle_cnt_q <= SET_W'(1)) state_q <= ST_ACQ;
                  end
               end
               ST_ACQ: begin
                  if (strb) begin
                     // Dropped samples still consume the window: acquisition is time-based.
                     if (full && !pop) overflow_q <= 1'b1;
                     if (sample_cnt_q != '0) sample_cnt_q <= sample_cnt_q - CNT_W'(1);
                     if (sample_cnt_q <= CNT_W'(1)) begin
                        state_q    <= ST_DRAIN;
                        cic_rstn_q <= 1'b0;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (level_q == '0) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  cic_rstn_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   // FIFO pointers and occupancy; abort flushes the contents.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (abort_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written, the head is gated by valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= cic_data_i;
   end

endmodule

// File: tb/tb_cic_acq_ctrl.sv
// Testbench for cic_acq_ctrl: a stand-in CIC produces a decimated clock and
// numbered samples; expected captured samples are queued as they are
// produced and compared as the DUT hands them out.
module tb_cic_acq_ctrl;

   localparam int DATA_W = 20;
   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W = 16;
   localparam int SETTLE = 2;
   localparam int LVL_W = 4;

   logic                 clk_i = 1'b0;
   logic                 rstn_i;
   logic                 start_i;
   logic                 abort_i;
   logic [CNT_W-1:0]     num_samples_i;
   logic [DATA_W-1:0]    cic_data_i;
   logic                 cic_clk_i;
   logic                 cic_rstn_o;
   logic [DATA_W-1:0]    m_data_o;
   logic                 m_valid_o;
   logic                 m_ready_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 overflow_o;
   logic [LVL_W-1:0]     fifo_level_o;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] sb_q[$];
   logic [DATA_W-1:0] exp_d;
   int edge_idx = 0;
   int sb_n = 0;
   int sb_limit = 0;
   int sb_pushed = 0;
   int n_pops = 0;
   int done_cnt = 0;
   int rise_ctr = 0;
   int div = 0;
   bit rise_now = 1'b0;

   cic_acq_ctrl #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .SETTLE_SAMPLES(SETTLE)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
      .num_samples_i(num_samples_i), .cic_data_i(cic_data_i), .cic_clk_i(cic_clk_i),
      .cic_rstn_o(cic_rstn_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
      .m_ready_i(m_ready_i), .busy_o(busy_o), .done_o(done_o),
      .overflow_o(overflow_o), .fifo_level_o(fifo_level_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in CIC: decimate-by-4 clock while released, new sample on each rise.
   initial begin
      cic_clk_i = 1'b0;
      cic_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         rise_now = 1'b0;
         if (cic_rstn_o !== 1'b1) begin
            div = 0;
            cic_clk_i = 1'b0;
         end else begin
            div = (div + 1) % 4;
            if (div == 2) begin
               rise_ctr++;
               edge_idx++;
               rise_now = 1'b1;
               cic_data_i = DATA_W'(32'h50000 + rise_ctr * 7);
               if (edge_idx > SETTLE && edge_idx <= SETTLE + sb_n && sb_pushed < sb_limit) begin
                  sb_q.push_back(cic_data_i);
                  sb_pushed++;
               end
            end
            cic_clk_i = (div >= 2);
         end
      end
   end

   // Output monitor: every pop is checked against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk_i);
         if (done_o === 1'b1) done_cnt++;
         if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
            n_pops++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pop_data: got %h, expected no output (nothing pending)", m_data_o);
            end else begin
               exp_d = sb_q.pop_front();
               if (m_data_o !== exp_d) begin
                  errors++;
                  $display("FAIL pop_data: got %h, expected %h", m_data_o, exp_d);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of run");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i); #2;
   endtask

   task automatic start_acq(input int n, input int limit);
      sb_n = n;
      sb_limit = limit;
      sb_pushed = 0;
      edge_idx = 0;
      num_samples_i = CNT_W'(n);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      #13;
      checks++; if (cic_rstn_o !== 1'b0) begin errors++; $display("FAIL reset_cic_rstn: got %b expected 0", cic_rstn_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid_o); end
      checks++; if (m_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", m_data_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
      checks++; if (fifo_level_o !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
      rstn_i = 1'b1;
      tick();
   endtask

   task automatic test_basic(input string tag);
      int p0, d0;
      m_ready_i = 1'b1;
      p0 = n_pops;
      d0 = done_cnt;
      start_acq(4, 1000);
      checks++; if (busy_o !== 1'b1 || cic_rstn_o !== 1'b1) begin errors++; $display("FAIL %s_start: got busy=%b cic_rstn=%b expected 1/1", tag, busy_o, cic_rstn_o); end
      for (int i = 0; i < 200 && done_o !== 1'b1; i++) tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1 within 200 cycles", tag, done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 0", tag, busy_o); end
      tick();
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b expected 0", tag, done_o); end
      checks++; if (n_pops - p0 != 4) begin errors++; $display("FAIL %s_count: got %0d expected 4", tag, n_pops - p0); end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL %s_pending: got %0d expected 0", tag, sb_q.size()); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL %s_overflow: got %b expected 0", tag, overflow_o); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt - d0); end
   endtask

   task automatic test_overflow();
      int p0;
      m_ready_i = 1'b0;
      p0 = n_pops;
      start_acq(12, FIFO_DEPTH);
      for (int i = 0; i < 100 && edge_idx < SETTLE + 1; i++) tick();
      tick();
      checks++; if (fifo_level_o !== 4'd1 || m_valid_o !== 1'b1 || m_data_o !== sb_q[0]) begin
         errors++; $display("FAIL ovf_first_latency: got level=%0d valid=%b data=%h expected 1/1/%h", fifo_level_o, m_valid_o, m_data_o, sb_q[0]);
      end
      for (int i = 0; i < 200 && !(busy_o === 1'b1 && cic_rstn_o === 1'b0); i++) tick();
      checks++; if (busy_o !== 1'b1 || cic_rstn_o !== 1'b0) begin errors++; $display("FAIL ovf_drain: got busy=%b cic_rstn=%b expected 1/0", busy_o, cic_rstn_o); end
      checks++; if (edge_idx != SETTLE + 12) begin errors++; $display("FAIL ovf_drain_edge: got %0d expected %0d", edge_idx, SETTLE + 12); end
      checks++; if (fifo_level_o !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
      m_ready_i = 1'b1;
      for (int i = 0; i < 100 && done_o !== 1'b1; i++) tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b expected 1", done_o); end
      tick();
      checks++; if (n_pops - p0 != 8 || sb_q.size() != 0) begin errors++; $display("FAIL ovf_count: got %0d pending=%0d expected 8 pending=0", n_pops - p0, sb_q.size()); end
   endtask

   task automatic test_full_pop();
      int p0;
      m_ready_i = 1'b0;
      p0 = n_pops;
      start_acq(9, 1000);
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fp_ovf_clear: got %b expected 0", overflow_o); end
      for (int i = 0; i < 200 && fifo_level_o !== 4'd8; i++) tick();
      checks++; if (fifo_level_o !== 4'd8) begin errors++; $display("FAIL fp_fill: got %0d expected 8", fifo_level_o); end
      for (int i = 0; i < 50 && !(rise_now && edge_idx == SETTLE + 9); i++) tick();
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      checks++; if (fifo_level_o !== 4'd8) begin errors++; $display("FAIL fp_level: got %0d expected 8", fifo_level_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fp_overflow: got %b expected 0", overflow_o); end
      m_ready_i = 1'b1;
      for (int i = 0; i < 100 && done_o !== 1'b1; i++) tick();
      tick();
      checks++; if (n_pops - p0 != 9 || sb_q.size() != 0) begin errors++; $display("FAIL fp_count: got %0d pending=%0d expected 9 pending=0", n_pops - p0, sb_q.size()); end
   endtask

   task automatic test_abort();
      int d0;
      m_ready_i = 1'b0;
      start_acq(6, 1000);
      for (int i = 0; i < 100 && sb_pushed < 2; i++) tick();
      tick();
      checks++; if (fifo_level_o !== 4'd2) begin errors++; $display("FAIL abort_pre_level: got %0d expected 2", fifo_level_o); end
      d0 = done_cnt;
      abort_i = 1'b1;
      sb_q.delete();
      tick();
      abort_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || cic_rstn_o !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b cic_rstn=%b expected 0/0", busy_o, cic_rstn_o); end
      checks++; if (fifo_level_o !== '0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL abort_flush: got level=%0d valid=%b expected 0/0", fifo_level_o, m_valid_o); end
      repeat (20) tick();
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
      num_samples_i = 16'd5;
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || cic_rstn_o !== 1'b0) begin errors++; $display("FAIL abort_vs_start: got busy=%b cic_rstn=%b expected 0/0", busy_o, cic_rstn_o); end
      repeat (3) tick();
   endtask

   task automatic test_ignored();
      int p0;
      num_samples_i = '0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_zero: got busy=%b expected 0", busy_o); end
      m_ready_i = 1'b1;
      p0 = n_pops;
      start_acq(3, 1000);
      for (int i = 0; i < 100 && edge_idx < SETTLE + 1; i++) tick();
      num_samples_i = 16'd10;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 200 && done_o !== 1'b1; i++) tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", done_o); end
      tick();
      checks++; if (n_pops - p0 != 3 || sb_q.size() != 0) begin errors++; $display("FAIL ign_count: got %0d pending=%0d expected 3 pending=0", n_pops - p0, sb_q.size()); end
   endtask

   task automatic test_async_reset();
      m_ready_i = 1'b1;
      start_acq(4, 1000);
      for (int i = 0; i < 100 && edge_idx < 1; i++) tick();
      checks++; if (busy_o !== 1'b1 || cic_rstn_o !== 1'b1) begin errors++; $display("FAIL arst_settle: got busy=%b cic_rstn=%b expected 1/1", busy_o, cic_rstn_o); end
      #4;
      rstn_i = 1'b0;
      #1;
      checks++; if ({cic_rstn_o, m_valid_o, busy_o, done_o, overflow_o, m_data_o, fifo_level_o} !== '0) begin
         errors++; $display("FAIL arst_outputs: got cic_rstn=%b valid=%b busy=%b done=%b ovf=%b data=%h level=%0d expected all 0",
                            cic_rstn_o, m_valid_o, busy_o, done_o, overflow_o, m_data_o, fifo_level_o);
      end
      sb_q.delete();
      #2;
      rstn_i = 1'b1;
      tick();
      test_basic("restart");
   endtask

   initial begin
      rstn_i = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      num_samples_i = '0;
      m_ready_i = 1'b0;
      test_reset();
      test_basic("basic");
      test_overflow();
      test_full_pop();
      test_abort();
      test_ignored();
      test_async_reset();
      repeat (5) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cic_acq_ctrl.md
# cic_acq_ctrl

Acquisition controller for the 2nd-order CIC decimator. It holds the CIC in reset while idle, releases it on a start command, and discards the pipeline-fill samples. It then captures a programmed number of decimated samples into a small show-ahead FIFO and streams them out over a valid/ready interface. It sits between the CIC (driving its reset and consuming its `cic_data_o`/`cic_clk_o`) and the downstream readout/DSP logic, in the same clock domain.

## Interface
- `DATA_W`, 20: width of the CIC output sample.
- `FIFO_DEPTH`, 8: sample FIFO depth; must be a power of 2 and ≥2.
- `CNT_W`, 16: width of the sample-count request.
- `SETTLE_SAMPLES`, 2: number of decimated samples discarded after CIC reset release; 0 is allowed.

Ports:
- `clk_i` in 1: clock, shared with the CIC.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start-acquisition pulse.
- `abort_i` in 1: abort-acquisition pulse.
- `num_samples_i` in `CNT_W`: samples to capture; sampled when `start_i` is accepted.
- `cic_data_i` in `DATA_W`: CIC decimated output.
- `cic_clk_i` in 1: CIC decimated-rate clock (counter MSB).
- `cic_rstn_o` out 1: active-low reset to the CIC; registered.
- `m_data_o` out `DATA_W`: output sample; this is the FIFO head.
- `m_valid_o` out 1: FIFO not empty.
- `m_ready_i` in 1: downstream accept.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `overflow_o` out 1: sticky flag, set when a sample was dropped because the FIFO was full.
- `fifo_level_o` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Sample strobe:** `strb = cic_clk_i & ~cic_clk_q`. `cic_clk_q` is a register of `cic_clk_i` and resets to 0. No synchronizer is used, because both blocks share the same clock. `cic_data_i` is captured in the strobe cycle.
- **States:** IDLE, SETTLE, ACQ, DRAIN.
- **IDLE:**
  - `cic_rstn_o` = 0.
  - `start_i` with `num_samples_i` ≠ 0 loads the sample counter, loads the settle counter with `SETTLE_SAMPLES`, clears `overflow_o`, and moves to SETTLE. If `SETTLE_SAMPLES` = 0 it moves directly to ACQ.
  - `start_i` with `num_samples_i` = 0 is ignored.
- **SETTLE:**
  - `cic_rstn_o` = 1.
  - Each strobe decrements the settle counter and the sample is discarded.
  - The strobe that brings the counter to 0 moves the state to ACQ.
- **ACQ:**
  - Each strobe attempts a FIFO write and decrements the sample counter.
  - The write is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - If the write is not accepted, the sample is dropped and `overflow_o` is set. A dropped sample still counts toward `num_samples_i`, so the acquisition window is time-based.
  - The strobe that brings the counter to 0 moves the state to DRAIN.
- **DRAIN:**
  - `cic_rstn_o` = 0; the CIC is stopped.
  - When the FIFO is empty the state moves to IDLE and `done_o` pulses for 1 cycle.
- **FIFO behaviour:**
  - A pop occurs when `m_valid_o & m_ready_i`.
  - The FIFO can be read in any state, including IDLE.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop on an empty FIFO: the push proceeds and `m_valid_o` rises next cycle.
- **abort_i:**
  - Has priority over all other events, including a same-cycle `start_i`.
  - Valid in any state; in IDLE it only flushes the FIFO.
  - Next cycle: state is IDLE, `cic_rstn_o` = 0, FIFO flushed (level 0, `m_valid_o` = 0).
  - No `done_o` pulse; `overflow_o` is retained.
- **Ignored inputs:** `start_i` while busy is ignored.
- **Arithmetic:** counters saturate at 0 and never wrap. No arithmetic is applied to the data; samples pass through unchanged.

## Timing
- **Reset values:** state IDLE, `cic_rstn_o` = 0, `m_valid_o` = 0, `m_data_o` = 0, `busy_o` = 0, `done_o` = 0, `overflow_o` = 0, `fifo_level_o` = 0, `cic_clk_q` = 0.
- **Start:** `start_i` at cycle T → `busy_o` = 1 and `cic_rstn_o` = 1 at T+1.
- **Strobe to output:** a strobe at cycle T with an accepted write → `m_valid_o` = 1 and `m_data_o` = sample at T+1. `fifo_level_o` updates at T+1.
- **End of acquisition:** the last ACQ strobe at T → state DRAIN and `cic_rstn_o` = 0 at T+1.
- **Completion:** the FIFO becomes empty at T (level 0 is visible) → `done_o` = 1 at T+1, coinciding with `busy_o` falling. If the FIFO is already empty on entering DRAIN, `done_o` pulses the cycle after entry.
- **Reset mid-operation:** `rstn_i` asserted at any time immediately forces all reset values. The FIFO contents are discarded.

## Test plan
- **Basic capture:** `SETTLE_SAMPLES`=2, `num_samples_i`=4, `m_ready_i`=1, CIC with constant input 1 → first 2 strobes discarded, exactly 4 samples output; `done_o` 1 cycle; `busy_o` 0 after; `overflow_o`=0.
- **Backpressure overflow:** `m_ready_i`=0, `num_samples_i`=12, `FIFO_DEPTH`=8 → `fifo_level_o` stops at 8; `overflow_o`=1; DRAIN entered after the 12th strobe. Then raise `m_ready_i` → exactly 8 samples (the first 8) emerge, followed by `done_o`.
- **Full with simultaneous pop:** FIFO at 8, strobe coincides with a pop → write accepted, level stays 8, `overflow_o` stays 0.
- **Abort mid-ACQ:** abort after 2 of 6 samples with a sample in the FIFO → next cycle IDLE, `fifo_level_o`=0, `m_valid_o`=0, `cic_rstn_o`=0, no `done_o`. `start_i`+`abort_i` in the same cycle from IDLE → remains IDLE.
- **Ignored commands:** `start_i` with `num_samples_i`=0 → `busy_o` remains 0. `start_i` pulsed during ACQ → captured count unchanged.
- **Async reset mid-SETTLE:** `rstn_i` low mid-SETTLE → all outputs at reset values immediately. A restart after deassertion behaves like the basic-capture test.
